// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op codes, FSM states,
// default width and the parallel logic-op helper used by the fast path.
package alu_pkg;

  localparam int ALU_WIDTH = 24;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SLT);
  endfunction

  // Whole-word version of the slice's logic ops; reserved codes yield zero.
  function automatic logic [ALU_WIDTH-1:0] fast_logic(input logic [ALU_WIDTH-1:0] a,
                                                     input logic [ALU_WIDTH-1:0] b,
                                                     input logic binv,
                                                     input logic [2:0] op);
    logic [ALU_WIDTH-1:0] bx;
    bx = b ^ {ALU_WIDTH{binv}};
    case (op)
      OP_AND:  return a & bx;
      OP_OR:   return a | bx;
      OP_XOR:  return a ^ bx;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/alu_serial_seq_if.sv
// Request/result handshake bundle between issue, the serial ALU and writeback.
interface alu_serial_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic             InValid;
  logic             InReady;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       Op;
  logic             BNeg;
  logic             OutValid;
  logic             OutReady;
  logic [WIDTH-1:0] Result;
  logic             CarryOut;
  logic             Overflow;
  logic             Zero;

  modport master (
    output InValid, A, B, Op, BNeg, OutReady,
    input  InReady, OutValid, Result, CarryOut, Overflow, Zero
  );

  modport slave (
    input  InValid, A, B, Op, BNeg, OutReady,
    output InReady, OutValid, Result, CarryOut, Overflow, Zero
  );

endinterface

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice; the sequencer feeds it one bit per cycle.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic       binv,
  input  logic [2:0] op,
  output logic       res,
  output logic       cout
);

  logic bx;
  logic sum;

  assign bx   = b ^ binv;
  assign sum  = a ^ bx ^ cin;
  assign cout = (a & bx) | (cin & (a ^ bx));

  always_comb begin
    res = 1'b0;
    case (op)
      OP_AND:  res = a & bx;
      OP_OR:   res = a | bx;
      OP_XOR:  res = a ^ bx;
      OP_ADD,
      OP_SLT:  res = sum;
      default: res = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: runs one alu_bit_slice LSB-first over WIDTH cycles.
// Define ALU_FASTLOGIC_EN to compute AND/OR/XOR/reserved ops in one cycle.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             Clock,
  input  logic             ResetN,
  alu_serial_seq_if.slave  bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [2:0]         op_q, op_d;
  logic               binv_q, binv_d;
  logic               carry_q, carry_d;
  logic               cmsb_q, cmsb_d;
  logic               nz_q, nz_d;

  logic               slice_res;
  logic               slice_cout;
  logic               less;
  logic               done;
  logic               arith;

  alu_bit_slice u_slice (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .binv (binv_q),
    .op   (op_q),
    .res  (slice_res),
    .cout (slice_cout)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_AND;
      binv_q  <= 1'b0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      nz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      binv_q  <= binv_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      nz_q    <= nz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    binv_d  = binv_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    nz_d    = nz_q;
    less    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.InValid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          op_d    = bus.Op;
          binv_d  = bus.BNeg | (bus.Op == OP_SLT);
          carry_d = bus.BNeg | (bus.Op == OP_SLT);
          cnt_d   = '0;
          cmsb_d  = 1'b0;
          res_d   = '0;
          nz_d    = 1'b0;
          state_d = SHIFT;
`ifdef ALU_FASTLOGIC_EN
          if (!is_arith(bus.Op)) begin
            res_d   = fast_logic(bus.A, bus.B, bus.BNeg, bus.Op);
            nz_d    = |fast_logic(bus.A, bus.B, bus.BNeg, bus.Op);
            carry_d = 1'b0;
            state_d = DONE;
          end
`endif
        end
      end

      // Slice output enters at the MSB so the word is aligned after WIDTH shifts.
      SHIFT: begin
        res_d   = {slice_res, res_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = slice_cout;
        nz_d    = nz_q | slice_res;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cmsb_d  = carry_q;
          state_d = (op_q == OP_SLT) ? FIXUP : DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Sign of the difference, corrected for overflow, is the less-than bit.
      FIXUP: begin
        less    = res_q[WIDTH-1] ^ cmsb_q ^ carry_q;
        res_d   = {{(WIDTH-1){1'b0}}, less};
        nz_d    = less;
        state_d = DONE;
      end

      DONE: begin
        if (bus.OutReady) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign done  = (state_q == DONE);
  assign arith = is_arith(op_q);

  assign bus.InReady  = ResetN && (state_q == IDLE);
  assign bus.OutValid = done;
  assign bus.Result   = res_q;
  assign bus.CarryOut = done & arith & carry_q;
  assign bus.Overflow = done & arith & (cmsb_q ^ carry_q);
  assign bus.Zero     = done & ~nz_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomized self-checking bench for alu_serial_seq against a word-level ALU model.
module tb_alu_serial_seq;
  import alu_pkg::*;

  localparam int W = ALU_WIDTH;

  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  alu_serial_seq_if bus ();

  alu_serial_seq dut (
    .Clock  (clk),
    .ResetN (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Word-level ALU: two's-complement arithmetic and signed compare.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic bneg);
    exp_t         e;
    logic         sub;
    logic [W-1:0] bx;
    logic [W:0]   wide;
    sub  = bneg || (op == OP_SLT);
    bx   = sub ? ~b : b;
    wide = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
    e.c  = 1'b0;
    e.v  = 1'b0;
    case (op)
      OP_AND: e.res = a & bx;
      OP_OR:  e.res = a | bx;
      OP_XOR: e.res = a ^ bx;
      OP_ADD: e.res = wide[W-1:0];
      OP_SLT: e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: e.res = '0;
    endcase
    if (op == OP_ADD || op == OP_SLT) begin
      e.c = wide[W];
      e.v = (a[W-1] == bx[W-1]) && (wide[W-1] != a[W-1]);
    end
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic int modelLatency(input logic [2:0] op);
    if (op == OP_SLT) return W + 1;
    if (op == OP_ADD) return W;
`ifdef ALU_FASTLOGIC_EN
    return 1;
`else
    return W;
`endif
  endfunction

  // Called just after the accept edge; counts edges until OutValid and checks the result.
  task automatic collectResult(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input logic bneg, input string tag);
    exp_t e;
    int   lat;
    bit   seen;
    e    = model(a, b, op, bneg);
    lat  = 0;
    seen = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.OutValid) begin
        seen = 1;
        lat  = i;
      end
    end
    checkOutput({tag, "_latency"}, lat, modelLatency(op));
    checkOutput({tag, "_result"}, 32'(bus.Result), 32'(e.res));
    checkOutput({tag, "_carry"}, 32'(bus.CarryOut), 32'(e.c));
    checkOutput({tag, "_ovf"}, 32'(bus.Overflow), 32'(e.v));
    checkOutput({tag, "_zero"}, 32'(bus.Zero), 32'(e.z));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    bus.OutReady = 1'b1;
    @(posedge clk);
    #1;
    bus.OutReady = 1'b0;
    checkOutput({tag, "_ovalid_drop"}, 32'(bus.OutValid), 32'd0);
    checkOutput({tag, "_inready_back"}, 32'(bus.InReady), 32'd1);
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input logic bneg, input string tag);
    @(negedge clk);
    bus.InValid = 1'b1;
    bus.A       = a;
    bus.B       = b;
    bus.Op      = op;
    bus.BNeg    = bneg;
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    bus.A       = W'($urandom);
    bus.B       = W'($urandom);
    collectResult(a, b, op, bneg, tag);
    handshake(tag);
  endtask

  initial begin
    bit           sawValid;
    logic [W-1:0] held;
    exp_t         e;

    testsRun        = 0;
    testsFailed     = 0;
    bus.InValid     = 1'b0;
    bus.A           = '0;
    bus.B           = '0;
    bus.Op          = OP_AND;
    bus.BNeg        = 1'b0;
    bus.OutReady    = 1'b0;
    rst_n           = 1'b1;
    #2 rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_inready", 32'(bus.InReady), 32'd0);
    checkOutput("rst_ovalid", 32'(bus.OutValid), 32'd0);
    checkOutput("rst_result", 32'(bus.Result), 32'd0);
    checkOutput("rst_zero", 32'(bus.Zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_inready", 32'(bus.InReady), 32'd1);
    checkOutput("post_rst_ovalid", 32'(bus.OutValid), 32'd0);
    checkOutput("post_rst_result", 32'(bus.Result), 32'd0);

    // Reset in the middle of an ADD must discard it.
    @(negedge clk);
    bus.InValid = 1'b1;
    bus.A       = 24'h000001;
    bus.B       = 24'hFFFFFF;
    bus.Op      = OP_ADD;
    bus.BNeg    = 1'b0;
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ovalid", 32'(bus.OutValid), 32'd0);
    checkOutput("midrst_inready", 32'(bus.InReady), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.OutValid) sawValid = 1;
    end
    checkOutput("midrst_no_output", 32'(sawValid), 32'd0);
    checkOutput("midrst_inready_after", 32'(bus.InReady), 32'd1);

    applyStimulus(24'h000001, 24'hFFFFFF, OP_ADD, 1'b0, "add_wrap");
    applyStimulus(24'h7FFFFF, 24'hFFFFFF, OP_ADD, 1'b1, "sub_ovf");
    applyStimulus(24'hFFFFFE, 24'h000003, OP_SLT, 1'b0, "slt_neg");
    applyStimulus(24'h000005, 24'h000005, OP_SLT, 1'b0, "slt_eq");
    applyStimulus(24'hA5A5A5, 24'hFFFF00, OP_XOR, 1'b0, "xor");
    applyStimulus(24'h123456, 24'h0F0F0F, 3'b110, 1'b0, "reserved");
    applyStimulus(24'h7FFFFF, 24'h000001, OP_ADD, 1'b0, "add_ovf");
    applyStimulus(24'h800000, 24'h7FFFFF, OP_SLT, 1'b1, "slt_minmax");

    // Backpressure: result held while a new request waits.
    @(negedge clk);
    bus.InValid = 1'b1;
    bus.A       = 24'h00F00F;
    bus.B       = 24'h0A0A0A;
    bus.Op      = OP_ADD;
    bus.BNeg    = 1'b0;
    @(posedge clk);
    #1;
    bus.A       = 24'h111111;
    bus.B       = 24'h222222;
    bus.Op      = OP_OR;
    collectResult(24'h00F00F, 24'h0A0A0A, OP_ADD, 1'b0, "bp_first");
    e    = model(24'h00F00F, 24'h0A0A0A, OP_ADD, 1'b0);
    held = e.res;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_result_stable", 32'(bus.Result), 32'(held));
      checkOutput("bp_inready_low", 32'(bus.InReady), 32'd0);
      checkOutput("bp_ovalid_high", 32'(bus.OutValid), 32'd1);
    end
    handshake("bp_release");
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    checkOutput("bp_second_accepted", 32'(bus.InReady), 32'd0);
    collectResult(24'h111111, 24'h222222, OP_OR, 1'b0, "bp_second");
    handshake("bp_second");

    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic [2:0]   rop;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 3'($urandom_range(0, 7));
      if (n % 8 == 0) rb = ra;
      if (n % 8 == 1) ra = 24'h800000;
      applyStimulus(ra, rb, rop, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial sequencer for the CPU's 24-bit ALU. It reuses one 1-bit ALU slice over WIDTH cycles, feeding it LSB-first.
- Owns the carry chain, the B-invert/carry-in setup for subtract, and the set-less-than fixup.
- Sits between the decode/issue stage (valid/ready input side) and writeback (valid/ready output side).

Parameters:
- WIDTH, 24, operand/result width in bits.
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- Clock  input  1  system clock; all state on rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- InValid  input  1  operation request valid.
- InReady  output  1  sequencer can accept a request.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Op  input  3  000 AND, 001 OR, 010 ADD, 011 SLT, 100 XOR, others reserved.
- BNeg  input  1  invert B and force carry-in 1 (SUB); ignored for SLT, which always subtracts.
- OutValid  output  1  result available.
- OutReady  input  1  consumer takes the result.
- Result  output  WIDTH  operation result.
- CarryOut  output  1  carry out of the MSB slice.
- Overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).
- Zero  output  1  Result == 0.

Behaviour:
- Reset (async, ResetN=0):
  - state=IDLE; counter=0; carry=0.
  - Result=0, CarryOut=0, Overflow=0, Zero=0, OutValid=0, InReady=0 while reset is held.
  - InReady=1 from the first cycle after release.
  - Reset mid-operation abandons the operation; no output is produced.
- States: IDLE, SHIFT, FIXUP, DONE.
- IDLE:
  - InReady=1.
  - On InValid&InReady: latch A, B, Op; set binv=BNeg|(Op==SLT); carry=binv; counter=0 → SHIFT.
- SHIFT (InReady=0):
  - Each cycle the slice processes bit[counter] of A and B (B XOR binv).
  - The slice output shifts into the result register MSB; the register shifts right.
  - carry register ← slice carry-out.
  - zero_acc ← zero_acc | output bit.
  - When counter==WIDTH-1:
    - latch carry_msb_in = carry before the update;
    - next state is FIXUP if Op==SLT, else DONE.
  - Otherwise counter+1.
- FIXUP (SLT only, 1 cycle):
  - Result = {WIDTH-1 zeros, less}, where less = sum_msb XOR overflow.
  - Zero = ~less → DONE.
- DONE:
  - OutValid=1; outputs stable until OutValid&OutReady, then → IDLE.
  - A new request is not accepted in the same cycle as the output handshake.
- Latency from the accept edge to OutValid: WIDTH edges (24), or WIDTH+1 for SLT.
- Throughput: one operation per WIDTH+2 cycles minimum.
- CarryOut/Overflow:
  - Meaningful for ADD/SLT.
  - For logic ops they are forced 0; the internal slice still evaluates the carry but it is masked.
- Reserved Op: treated as AND-free zero. Slice outputs are masked to 0; Result=0, Zero=1, flags 0; same latency as ADD.
- OutReady held low: stays in DONE indefinitely; InReady stays 0.
- InValid while busy: ignored (no InReady). The requester must hold its request.

Optional Feature:
- Macro ALU_FASTLOGIC_EN.
- Defined:
  - AND/OR/XOR (and reserved Op) bypass SHIFT.
  - The accept edge computes all WIDTH bits in parallel straight into the result register and goes to DONE.
  - OutValid is 1 edge after accept; flags as above.
- Undefined: all ops take the serial path.
- ADD/SLT timing is identical in both cases.

Decomposition:
- Shared package alu_pkg:
  - Op encodings OP_AND=3'b000, OP_OR=3'b001, OP_ADD=3'b010, OP_SLT=3'b011, OP_XOR=3'b100;
  - state encoding (IDLE=0, SHIFT=1, FIXUP=2, DONE=3);
  - WIDTH default 24.
- One sub-module: alu_bit_slice.
  - Combinational 1-bit slice with inputs a, b, cin, binv, op; outputs res, cout.
  - Instantiated once inside the sequencer.

Test Plan:
- After reset: Result=0, OutValid=0, InReady=1. Assert ResetN low during SHIFT of an ADD → OutValid never rises; InReady=1 after release.
- ADD A=0x000001, B=0xFFFFFF → Result=0x000000, CarryOut=1, Zero=1, Overflow=0; OutValid exactly 24 edges after accept.
- SUB (Op=ADD, BNeg=1) A=0x7FFFFF, B=0xFFFFFF → Result=0x800000, Overflow=1, CarryOut=0.
- SLT A=0xFFFFFE (-2), B=0x000003 → Result=0x000001, Zero=0, latency 25. Also A=5, B=5 → Result=0, Zero=1.
- XOR A=0xA5A5A5, B=0xFFFF00 → Result=0x5A5AA5, CarryOut=0. Latency is 24 without ALU_FASTLOGIC_EN and 1 with it.
- Backpressure: hold OutReady=0 for 10 cycles after OutValid, with InValid=1 throughout → Result stable, InReady=0; on the OutReady pulse → IDLE, then the next request is accepted one cycle later.
